vga_sync_gen: RTL and testbench

Generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock.
Drives horiz_sync, vert_sync, video_on, pixel_row and pixel_column to the game/graphics stage and the DAC pins.
Sits directly upstream of the snake renderer, which uses vert_sync as its frame tick and pixel_row 480..488 as a blanking-time write window.
pixel_row and pixel_column therefore count through blanking and are never clamped to the visible area.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_timing_counter.sv | 40 ++++
 rtl/vga_sync_gen.sv | 123 ++++++++++++
 tb/tb_vga_sync_gen.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60), sync polarities and the coordinate type.
// The display stage and the snake renderer both use these bounds.
package vga_pkg;

  localparam int VGA_COORD_W = 10;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // 0 = active-low sync pulses
  localparam logic VGA_HS_POL = 1'b0;
  localparam logic VGA_VS_POL = 1'b0;

  typedef logic [VGA_COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_timing_counter.sv
// One axis of VGA timing: a wrapping counter with combinational active/sync/wrap decode.
// Instantiated once per axis; the top registers all decoded outputs.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int   VISIBLE = VGA_H_VISIBLE,
  parameter int   FRONT   = VGA_H_FRONT,
  parameter int   SYNC    = VGA_H_SYNC,
  parameter int   BACK    = VGA_H_BACK,
  parameter logic POL     = VGA_HS_POL
) (
  input  logic                   pixel_clock,
  input  logic                   reset,
  input  logic                   enable,
  output logic [VGA_COORD_W-1:0] count,
  output logic                   active,
  output logic                   sync,
  output logic                   wrap
);

  localparam int     TOTAL      = VISIBLE + FRONT + SYNC + BACK;
  localparam coord_t LAST       = coord_t'(TOTAL - 1);
  localparam coord_t VIS_LIMIT  = coord_t'(VISIBLE);
  localparam coord_t SYNC_FIRST = coord_t'(VISIBLE + FRONT);
  localparam coord_t SYNC_LAST  = coord_t'(VISIBLE + FRONT + SYNC - 1);

  // Anything at or beyond the last position wraps, so stray values self-heal in one step.
  assign wrap   = (count >= LAST);
  assign active = (count < VIS_LIMIT);
  assign sync   = ((count >= SYNC_FIRST) && (count <= SYNC_LAST)) ? POL : ~POL;

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + coord_t'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: registered, mutually aligned sync/blank/coordinate outputs.
// Optional frame counter output when VGA_SYNC_FRAME_CNT_EN is defined.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   H_VISIBLE = VGA_H_VISIBLE,
  parameter int   H_FRONT   = VGA_H_FRONT,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BACK    = VGA_H_BACK,
  parameter int   V_VISIBLE = VGA_V_VISIBLE,
  parameter int   V_FRONT   = VGA_V_FRONT,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BACK    = VGA_V_BACK,
  parameter logic HS_POL    = VGA_HS_POL,
  parameter logic VS_POL    = VGA_VS_POL
) (
  input  logic                   pixel_clock,
  input  logic                   reset,
  output logic                   horiz_sync,
  output logic                   vert_sync,
  output logic                   video_on,
  output logic [VGA_COORD_W-1:0] pixel_column,
  output logic [VGA_COORD_W-1:0] pixel_row,
  output logic                   frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [15:0]            frame_count
`endif
);

  coord_t h_cnt, v_cnt;
  logic   h_active, h_sync, h_wrap;
  logic   v_active, v_sync, v_wrap;

  vga_timing_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .POL     (HS_POL)
  ) u_h_counter (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .enable      (1'b1),
    .count       (h_cnt),
    .active      (h_active),
    .sync        (h_sync),
    .wrap        (h_wrap)
  );

  vga_timing_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .POL     (VS_POL)
  ) u_v_counter (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .enable      (h_wrap),
    .count       (v_cnt),
    .active      (v_active),
    .sync        (v_sync),
    .wrap        (v_wrap)
  );

  // Stage p0: counters about to land on (0,0). Cleared by reset, so the
  // position shown right after release never fires frame_start.
  logic origin_p0;

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      origin_p0 <= 1'b0;
    end else begin
      origin_p0 <= h_wrap & v_wrap;
    end
  end

  // Stage p1: registered outputs, all decoded from the same counter snapshot.
  logic   hs_p1, vs_p1, video_p1, fs_p1;
  coord_t col_p1, row_p1;

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      hs_p1    <= ~HS_POL;
      vs_p1    <= ~VS_POL;
      video_p1 <= 1'b0;
      fs_p1    <= 1'b0;
      col_p1   <= '0;
      row_p1   <= '0;
    end else begin
      hs_p1    <= h_sync;
      vs_p1    <= v_sync;
      video_p1 <= h_active & v_active;
      fs_p1    <= origin_p0;
      col_p1   <= h_cnt;
      row_p1   <= v_cnt;
    end
  end

  assign horiz_sync   = hs_p1;
  assign vert_sync    = vs_p1;
  assign video_on     = video_p1;
  assign frame_start  = fs_p1;
  assign pixel_column = col_p1;
  assign pixel_row    = row_p1;

`ifdef VGA_SYNC_FRAME_CNT_EN
  // Steps on the same edge that raises frame_start; wraps naturally at 16 bits.
  logic [15:0] frame_cnt_p1;

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      frame_cnt_p1 <= '0;
    end else if (origin_p0) begin
      frame_cnt_p1 <= frame_cnt_p1 + 16'd1;
    end
  end

  assign frame_count = frame_cnt_p1;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: short lines (to keep frames brief), full 525-line frames.
module tb_vga_sync_gen;

  localparam int HV = 10, HF = 2, HS = 3, HB = 5;
  localparam int HT = HV + HF + HS + HB;
  localparam int VV = 480, VF = 10, VS = 2, VB = 33;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       pixel_clock = 1'b0;
  logic       reset = 1'b0;
  logic       horiz_sync, vert_sync, video_on, frame_start;
  logic [9:0] pixel_column, pixel_row;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] frame_count;
  logic [15:0] exp_fc;
`endif

  vga_sync_gen #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .HS_POL    (1'b0), .VS_POL (1'b0)
  ) dut (
    .pixel_clock  (pixel_clock),
    .reset        (reset),
    .horiz_sync   (horiz_sync),
    .vert_sync    (vert_sync),
    .video_on     (video_on),
    .pixel_column (pixel_column),
    .pixel_row    (pixel_row),
    .frame_start  (frame_start)
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    .frame_count  (frame_count)
`endif
  );

  always #5 pixel_clock = ~pixel_clock;

  int n_total = 0;
  int n_pass  = 0;
  int t       = 0;   // output samples since the first edge after reset release
  int first_fs, hs_low, vs_low, max_row;
  logic prev_hs, prev_vs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, exp, t);
  endtask

  task automatic check_reset_values(input string ph);
    check({ph, "_hs"},    horiz_sync,   1);
    check({ph, "_vs"},    vert_sync,    1);
    check({ph, "_video"}, video_on,     0);
    check({ph, "_col"},   pixel_column, 0);
    check({ph, "_row"},   pixel_row,    0);
    check({ph, "_fs"},    frame_start,  0);
`ifdef VGA_SYNC_FRAME_CNT_EN
    check({ph, "_fc"},    frame_count,  0);
`endif
  endtask

  task automatic restart_measure();
    t = 0; first_fs = -1; hs_low = 0; vs_low = 0; max_row = 0;
    prev_hs = 1'b1; prev_vs = 1'b1;
`ifdef VGA_SYNC_FRAME_CNT_EN
    exp_fc = 16'd0;
`endif
  endtask

  // Reference: outputs at sample t follow directly from the raw raster position t.
  task automatic run(input int n);
    int col, row;
    logic e_hs, e_vs, e_vid, e_fs;
    for (int i = 0; i < n; i++) begin
      @(posedge pixel_clock);
      @(negedge pixel_clock);
      col   = t % HT;
      row   = (t / HT) % VT;
      e_hs  = !(col >= HV + HF && col < HV + HF + HS);
      e_vs  = !(row >= VV + VF && row < VV + VF + VS);
      e_vid = (col < HV) && (row < VV);
      e_fs  = (t > 0) && (t % FRAME == 0);
      check("pixel_column", pixel_column, col);
      check("pixel_row",    pixel_row,    row);
      check("horiz_sync",   horiz_sync,   e_hs);
      check("vert_sync",    vert_sync,    e_vs);
      check("video_on",     video_on,     e_vid);
      check("frame_start",  frame_start,  e_fs);
`ifdef VGA_SYNC_FRAME_CNT_EN
      if (e_fs) exp_fc = exp_fc + 16'd1;
      check("frame_count",  frame_count,  exp_fc);
`endif
      if (horiz_sync === 1'b0) hs_low++;
      else begin
        if (prev_hs === 1'b0) begin
          check("hs_low_width", hs_low, HS);
          check("hs_rise_col",  pixel_column, HV + HF + HS);
        end
        hs_low = 0;
      end
      if (vert_sync === 1'b0) vs_low++;
      else begin
        if (prev_vs === 1'b0) begin
          check("vs_low_width", vs_low, VS * HT);
          check("vs_rise_row",  pixel_row, VV + VF + VS);
          check("vs_rise_col",  pixel_column, 0);
        end
        vs_low = 0;
      end
      prev_hs = horiz_sync;
      prev_vs = vert_sync;
      if (int'(pixel_row) > max_row) max_row = int'(pixel_row);
      if (frame_start === 1'b1 && first_fs < 0) first_fs = t;
      t++;
    end
  endtask

  initial begin
    int target_col;
    restart_measure();

    // Reset held 10 clocks
    for (int i = 0; i < 10; i++) begin
      @(posedge pixel_clock);
      @(negedge pixel_clock);
      check_reset_values("in_reset");
    end
    reset = 1'b1;

    // First frame plus wrap into the next: blanking rows, syncs, first frame_start
    run(FRAME + 2);
    check("first_fs_latency", first_fs, FRAME);
    check("max_row", max_row, VT - 1);

    // Advance to row 300 at a random column, then reset asynchronously mid-cycle
    target_col = int'($urandom_range(HT - 1, 1));
    run(FRAME + 300 * HT + target_col + 1 - t);
    check("pre_reset_row", pixel_row, 300);
    check("pre_reset_col", pixel_column, target_col);
    #($urandom_range(3, 1));
    reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge pixel_clock);
      @(negedge pixel_clock);
      check_reset_values("mid_reset");
    end
    reset = 1'b1;
    restart_measure();

    run(3 * FRAME + 2);
    check("fs_latency_after_reset", first_fs, FRAME);
`ifdef VGA_SYNC_FRAME_CNT_EN
    check("frame_count_3", frame_count, 3);
    force dut.frame_cnt_p1 = 16'hFFFF;
    #1;
    release dut.frame_cnt_p1;
    exp_fc = 16'hFFFF;
    check("frame_count_forced", frame_count, 16'hFFFF);
    run(FRAME);
    check("frame_count_wrap", frame_count, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
